// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU: opcodes, ALU codes,
// instruction field positions, sequencer states and instruction classes.
// Used by instr_decode and instr_sequencer (BRZ gated by INSTR_SEQ_BRZ_EN).
package cpu_pkg;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_BRZ = 4'h7;

  localparam logic [7:0] ALU_AND = 8'h00;
  localparam logic [7:0] ALU_OR  = 8'h01;
  localparam logic [7:0] ALU_ADD = 8'h02;
  localparam logic [7:0] ALU_SUB = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LD, CL_ST, CL_JMP, CL_BRZ
  } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: opcode -> {class, alu_op, legal}.
// Opcode 7 decodes as BRZ only when INSTR_SEQ_BRZ_EN is defined,
// otherwise it is reported illegal like every other unused opcode.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output iclass_t    class_o,
  output logic [7:0] alu_op_o,
  output logic       legal_o
);

  // Map opcode to instruction class and ALU code; unknown opcodes are illegal
  always_comb begin
    class_o  = CL_ALU;
    alu_op_o = 8'h00;
    legal_o  = 1'b1;
    case (opcode_i)
      OP_AND: alu_op_o = ALU_AND;
      OP_OR:  alu_op_o = ALU_OR;
      OP_ADD: alu_op_o = ALU_ADD;
      OP_SUB: alu_op_o = ALU_SUB;
      OP_LD:  class_o  = CL_LD;
      OP_ST:  class_o  = CL_ST;
      OP_JMP: class_o  = CL_JMP;
`ifdef INSTR_SEQ_BRZ_EN
      OP_BRZ: class_o  = CL_BRZ;
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR and the memory port.
// ALU/JMP take 3 cycles, LD/ST 4, plus one per mem_ack wait cycle.
// Optional BRZ (opcode 7) is enabled by defining INSTR_SEQ_BRZ_EN.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [1:0]         mem_wdata_sel,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [7:0]         alu_op,
  output logic [1:0]         rd_sel,
  output logic [1:0]         rs_sel,
  output logic               reg_we,
  output logic               wb_sel,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  pc,
  output logic               illegal,
  output logic               busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                illegal_q, illegal_d;

  iclass_t             dec_class;
  logic [7:0]          dec_alu_op;
  logic                dec_legal;
  logic [ADDR_W-1:0]   imm_addr;
  logic                take_branch;

  instr_decode u_decode (
    .opcode_i (ir_q[OPC_MSB:OPC_LSB]),
    .class_o  (dec_class),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  assign imm_addr = ADDR_W'(ir_q[IMM_MSB:IMM_LSB]);
  assign pc       = pc_q;
  assign illegal  = illegal_q;

`ifdef INSTR_SEQ_BRZ_EN
  assign take_branch = zero_flag;
`else
  // BRZ never decodes in this build, so the flag has no consumer
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
  assign take_branch      = 1'b0;
`endif

  // State, PC, IR and sticky illegal flag; reset aborts any transaction at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and per-cycle datapath/memory strobes
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    illegal_d     = illegal_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata_sel = 2'b00;
    alu_op        = 8'h00;
    rd_sel        = 2'b00;
    rs_sel        = 2'b00;
    reg_we        = 1'b0;
    wb_sel        = 1'b0;
    busy          = 1'b1;

    // Register selects stay valid from DECODE until the instruction retires
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM) begin
      rd_sel = ir_q[RD_MSB:RD_LSB];
      rs_sel = ir_q[RS_MSB:RS_LSB];
    end

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // run is only looked at on instruction boundaries
        state_d = run ? S_FETCH : S_IDLE;
        case (dec_class)
          CL_ALU: begin
            alu_op = dec_alu_op;
            reg_we = 1'b1;
          end
          CL_JMP: pc_d = imm_addr;
          CL_BRZ: if (take_branch) pc_d = imm_addr;
          CL_LD, CL_ST: state_d = S_MEM;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = imm_addr;
        if (dec_class == CL_ST) begin
          mem_we        = 1'b1;
          mem_wdata_sel = ir_q[RD_MSB:RD_LSB];
        end
        if (mem_ack) begin
          // LD writes the register file straight from mem_rdata in the ack cycle
          if (dec_class == CL_LD) begin
            reg_we = 1'b1;
            wb_sel = 1'b1;
          end
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_TRAP: busy = 1'b0;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU.
- Owns PC and instruction register (IR), and is the sole master of the shared instruction/data memory port (req/ack handshake).
- Drives per-cycle datapath strobes: ALU op, register write enable, writeback select.
- Sits between memory, register file and ALU; opcode decode is internal.

Parameters:
- ADDR_W, 8, memory address and PC width.
- INSTR_W, 16, instruction and memory data width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = sequence instructions, 0 = park in IDLE at the next instruction boundary.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write; valid while mem_req.
- mem_addr  out  ADDR_W  memory address; valid while mem_req.
- mem_wdata_sel  out  2  register index whose value is the store data (= rd).
- mem_ack  in  1  completes the request; may be high in the same cycle mem_req rises.
- mem_rdata  in  INSTR_W  read data; valid when mem_ack is high.
- alu_op  out  8  ALU operation code.
- rd_sel  out  2  destination/first-source register index.
- rs_sel  out  2  second-source register index.
- reg_we  out  1  one-cycle register-file write strobe.
- wb_sel  out  1  0 = ALU result, 1 = mem_rdata.
- zero_flag  in  1  ALU zero flag; used only with the optional feature.
- pc  out  ADDR_W  current PC.
- illegal  out  1  sticky illegal-opcode flag.
- busy  out  1  high in every state except IDLE and TRAP.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB: alu_op = zero-extended opcode (0x00..0x03).
  - 4 LD, 5 ST, 6 JMP.
  - Anything else is illegal.
- Reset values: state=IDLE, pc=RESET_PC, IR=0, illegal=0. mem_req, mem_we, reg_we, wb_sel, busy are 0; alu_op, rd_sel, rs_sel, mem_addr are 0.
- Reset mid-transaction aborts immediately; no pending request survives.
- State machine (IDLE, FETCH, DECODE, EXEC, MEM, TRAP):
  - IDLE: when run=1, go to FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc.
    - On mem_ack: IR<=mem_rdata, pc<=pc+1 (modulo 2^ADDR_W; 0xFF wraps to 0x00), go to DECODE.
    - Without ack: stay, outputs held stable.
  - DECODE: one cycle; rd_sel/rs_sel driven from IR from here through the end of the instruction.
    - Illegal opcode: illegal<=1, go to TRAP.
    - Otherwise go to EXEC.
  - EXEC:
    - ALU ops: alu_op valid, reg_we=1, wb_sel=0 for exactly this cycle; then FETCH (IDLE if run=0).
    - JMP: pc<=imm; then FETCH (IDLE if run=0).
    - LD/ST: go to MEM.
  - MEM: mem_req=1, mem_addr=imm.
    - LD: mem_we=0; in the mem_ack cycle reg_we=1 and wb_sel=1, so the register file captures mem_rdata directly.
    - ST: mem_we=1, mem_wdata_sel=rd; completes on mem_ack.
    - After ack: FETCH (IDLE if run=0).
  - TRAP: all strobes 0; exit only via reset.
- Latency with zero-wait memory:
  - ALU op or JMP: 3 cycles.
  - LD/ST: 4 cycles.
  - Each wait cycle on mem_ack adds 1.
- run is sampled only at instruction boundaries (leaving EXEC/MEM, or in IDLE). Deasserting run mid-instruction never truncates the instruction.
- reg_we and mem_req are never high in the same cycle, except LD completion in MEM.
- mem_req never drops before mem_ack.

Optional Feature:
- Macro: INSTR_SEQ_BRZ_EN.
- Defined: opcode 7 is BRZ. In EXEC, if zero_flag=1 then pc<=imm, else pc unchanged; latency 3 cycles.
- Undefined: opcode 7 is illegal (goes to TRAP); zero_flag is ignored.

Decomposition:
- Shared package, cpu_pkg:
  - Opcode constants (OP_AND..OP_JMP, OP_BRZ).
  - ALU op codes.
  - Instruction field bit positions.
  - State enum.
- Sub-module instr_decode (combinational): IR maps to {class, alu_op, legal}. The FSM and PC stay in instr_sequencer.

Test Plan:
- Reset, run=1, mem[0]=0x2600 (ADD r1,r2), zero-wait ack -> mem_req at addr 0x00; reg_we=1 with alu_op=0x02, rd_sel=1, rs_sel=2 in cycle 3; pc=0x01.
- LD: mem[1]=0x4C20, 2 wait cycles on the data access -> MEM holds mem_addr=0x20; reg_we=1 and wb_sel=1 only in the ack cycle; rd_sel=3.
- JMP: mem[0xFF]=0x6010 -> pc goes 0xFF, then 0x00 (wrap), then 0x10; next fetch at 0x10.
- Illegal opcode 0x9000 -> illegal=1 and busy=0 after DECODE; no further mem_req until reset.
- Drop run during a stalled ST fetch; reset asserted mid-MEM -> ST still completes with mem_we=1 then IDLE; the reset case drops mem_req asynchronously and returns pc=0x00.
- With INSTR_SEQ_BRZ_EN, 0x7040 -> zero_flag=1 gives pc=0x40; zero_flag=0 gives pc+1. Without the macro, 0x7040 -> TRAP.
